// File: rtl/booth_product_accumulator_if.sv
// Handshake and data bundle between the Booth multiplier front end and the
// product accumulator. master = upstream driver/consumer, slave = accumulator.
interface booth_product_accumulator_if #(
    parameter int unsigned PROD_W = 64,
    parameter int unsigned ACC_W  = 72,
    parameter int unsigned CNT_W  = 8
);
    logic              start;
    logic [CNT_W-1:0]  len;
    logic [PROD_W-1:0] prod;
    logic              prod_valid;
    logic              busy;
    logic [ACC_W-1:0]  acc_full;
    logic [PROD_W-1:0] acc_out;
    logic              ovf;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output start, len, prod, prod_valid, out_ready,
        input  busy, acc_full, acc_out, ovf, out_valid
    );

    modport slave (
        input  start, len, prod, prod_valid, out_ready,
        output busy, acc_full, acc_out, ovf, out_valid
    );
endinterface

// File: rtl/booth_product_accumulator.sv
// Accumulates a programmed burst of signed products into a guard-banded
// accumulator and presents the 64-bit saturated sum via valid/ready.
module booth_product_accumulator #(
    parameter int unsigned PROD_W = 64,
    parameter int unsigned ACC_W  = 72,
    parameter int unsigned CNT_W  = 8
) (
    input logic clk,
    input logic reset,
    booth_product_accumulator_if.slave bus
);

    localparam int unsigned EXT_W = ACC_W - PROD_W;
    localparam int unsigned HI_W  = ACC_W - PROD_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic              out_valid;

    logic [ACC_W-1:0]  prod_ext;
    logic [HI_W-1:0]   acc_hi;
    logic              in_range;
    logic [PROD_W-1:0] sat_out;
    logic              sat_ovf;

    assign prod_ext = {{EXT_W{bus.prod[PROD_W-1]}}, bus.prod};

    // Sum fits in PROD_W signed iff the guard bits all match the PROD_W sign bit.
    assign acc_hi   = acc[ACC_W-1:PROD_W-1];
    assign in_range = (&acc_hi) | ~(|acc_hi);

    always_comb begin
        sat_ovf = 1'b0;
        sat_out = acc[PROD_W-1:0];
        if (!in_range) begin
            sat_ovf = 1'b1;
            sat_out = acc[ACC_W-1] ? {1'b1, {(PROD_W-1){1'b0}}}
                                   : {1'b0, {(PROD_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc  <= '0;
                        cnt  <= bus.len;
                        busy <= 1'b1;
                        if (bus.len != '0) begin
                            state <= ACC;
                        end else begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (bus.prod_valid) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.acc_full  = acc;
    assign bus.acc_out   = sat_out;
    assign bus.ovf       = sat_ovf;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed scoreboard bench for booth_product_accumulator: driver queues the
// expected result of each burst, monitor checks whatever the DUT presents.
module tb_booth_product_accumulator;

    localparam int unsigned PROD_W = 64;
    localparam int unsigned ACC_W  = 72;
    localparam int unsigned CNT_W  = 8;

    typedef struct {
        logic [ACC_W-1:0]  full;
        logic [PROD_W-1:0] out;
        logic              ovf;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    booth_product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    booth_product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ACC_W-1:0] full, input logic [PROD_W-1:0] out, input logic ovf);
        exp_t e;
        e.full = full;
        e.out  = out;
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    task automatic start_burst(input logic [CNT_W-1:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", ACC_W'(bus.busy), ACC_W'(1));
        check("out_valid_after_start", ACC_W'(bus.out_valid), (n == '0) ? ACC_W'(1) : ACC_W'(0));
    endtask

    task automatic send(input logic [PROD_W-1:0] p);
        bus.prod       = p;
        bus.prod_valid = 1'b1;
        tick();
        bus.prod_valid = 1'b0;
    endtask

    // Bounded wait for the result to appear and then be consumed.
    task automatic wait_done();
        int i;
        bus.out_ready = 1'b1;
        i = 0;
        while (!bus.out_valid && i < 20) begin
            tick();
            i++;
        end
        if (!bus.out_valid) check("timeout_out_valid_rise", ACC_W'(bus.out_valid), ACC_W'(1));
        i = 0;
        while (bus.out_valid && i < 20) begin
            tick();
            i++;
        end
        check("out_valid_drop", ACC_W'(bus.out_valid), ACC_W'(0));
        check("busy_drop", ACC_W'(bus.busy), ACC_W'(0));
    endtask

    // Monitor: every cycle the result is presented it must match the head of
    // the scoreboard; the entry retires on the handshake.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", ACC_W'(bus.out_valid), ACC_W'(0));
            end else begin
                check("mon_acc_full", bus.acc_full, sb[0].full);
                check("mon_acc_out", ACC_W'(bus.acc_out), ACC_W'(sb[0].out));
                check("mon_ovf", ACC_W'(bus.ovf), ACC_W'(sb[0].ovf));
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.prod       = '0;
        bus.prod_valid = 1'b0;
        bus.out_ready  = 1'b1;

        @(negedge clk);
        check("rst_busy", ACC_W'(bus.busy), ACC_W'(0));
        check("rst_out_valid", ACC_W'(bus.out_valid), ACC_W'(0));
        check("rst_acc_full", bus.acc_full, ACC_W'(0));
        check("rst_acc_out", ACC_W'(bus.acc_out), ACC_W'(0));
        check("rst_ovf", ACC_W'(bus.ovf), ACC_W'(0));
        reset = 1'b0;
        tick();

        // Two back-to-back products
        push(72'd321597444, 64'd321597444, 1'b0);
        start_burst(8'd2);
        send(64'd464960160);
        check("t1_in_acc", ACC_W'(bus.out_valid), ACC_W'(0));
        send(-64'sd143362716);
        check("t1_latency", ACC_W'(bus.out_valid), ACC_W'(1));
        wait_done();
        tick();

        // Gapped products with downstream backpressure
        bus.out_ready = 1'b0;
        push(72'd10, 64'd10, 1'b0);
        start_burst(8'd3);
        send(64'd5);
        tick();
        send(64'd7);
        tick();
        send(-64'sd2);
        check("t2_latency", ACC_W'(bus.out_valid), ACC_W'(1));
        repeat (5) tick();
        check("t2_held", ACC_W'(bus.out_valid), ACC_W'(1));
        bus.out_ready = 1'b1;
        tick();
        check("t2_drop_valid", ACC_W'(bus.out_valid), ACC_W'(0));
        check("t2_drop_busy", ACC_W'(bus.busy), ACC_W'(0));
        tick();

        // Positive saturation
        push(72'h00_FFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        start_burst(8'd2);
        send(64'h7FFF_FFFF_FFFF_FFFF);
        send(64'h7FFF_FFFF_FFFF_FFFF);
        wait_done();
        tick();

        // Negative saturation
        push(72'hFF_0000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        start_burst(8'd2);
        send(64'h8000_0000_0000_0000);
        send(64'h8000_0000_0000_0000);
        wait_done();

        // Products strobed while idle must not touch the frozen sum
        send(64'd1000);
        send(64'd2000);
        check("idle_prod_ignored", bus.acc_full, 72'hFF_0000_0000_0000_0000);
        push(72'd42, 64'd42, 1'b0);
        start_burst(8'd1);
        send(64'd42);
        wait_done();
        tick();

        // Zero-length burst
        push(72'd0, 64'd0, 1'b0);
        start_burst(8'd0);
        wait_done();
        tick();

        // start during ACC must not reload the count
        push(72'd7, 64'd7, 1'b0);
        start_burst(8'd2);
        send(64'd3);
        bus.start = 1'b1;
        bus.len   = 8'd5;
        tick();
        bus.start = 1'b0;
        check("acc_start_ignored_busy", ACC_W'(bus.busy), ACC_W'(1));
        send(64'd4);
        check("acc_start_ignored_done", ACC_W'(bus.out_valid), ACC_W'(1));
        wait_done();
        tick();

        // Asynchronous reset mid-burst
        start_burst(8'd4);
        send(64'd100);
        send(64'd200);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", ACC_W'(bus.busy), ACC_W'(0));
        check("mid_rst_acc_full", bus.acc_full, ACC_W'(0));
        check("mid_rst_out_valid", ACC_W'(bus.out_valid), ACC_W'(0));
        tick();
        reset = 1'b0;
        tick();
        push(-72'sd259, -64'sd259, 1'b0);
        start_burst(8'd1);
        send(-64'sd259);
        wait_done();
        tick();

        check("sb_empty", ACC_W'(sb.size()), ACC_W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Downstream consumer of the registered radix-4 Booth multiplier. It accumulates a programmed number of signed 64-bit products into a 72-bit guard-banded accumulator, which makes it the MAC back end for dot-product style use of the multiplier. It presents the final sum, saturated to 64 bits with an overflow flag, through a valid/ready output handshake. Input products arrive with a qualifying strobe, so the multiplier's pipeline latency is absorbed by whoever drives `prod_valid`.

## Interface
- `PROD_W`, 64: product width (signed two's complement)
- `ACC_W`, 72: internal accumulator width; must be ≥ PROD_W + 8
- `CNT_W`, 8: width of the length field; maximum burst is 2^CNT_W − 1 products
- `clk` input 1: single clock, rising-edge
- `reset` input 1: asynchronous, active-high; clears all state
- `start` input 1: begin a new accumulation burst; sampled only in IDLE
- `len` input CNT_W: number of products in the burst; sampled with `start`
- `prod` input PROD_W: signed product from the multiplier
- `prod_valid` input 1: `prod` is valid this cycle
- `busy` output 1: high in ACC and HOLD
- `acc_full` output ACC_W: raw accumulator contents
- `acc_out` output PROD_W: `acc_full` saturated to PROD_W signed
- `ovf` output 1: `acc_out` is saturated (combinational from `acc_full`)
- `out_valid` output 1: result available
- `out_ready` input 1: downstream accepts the result

## Operation
- FSM states: IDLE, ACC, HOLD. Reset state is IDLE.
- Reset values: `acc` = 0, `cnt` = 0, `busy` = 0, `out_valid` = 0, `acc_out` = 0, `ovf` = 0.
- IDLE, `start`=1, `len`≠0: clear `acc`, load `cnt`←`len`, go to ACC.
- IDLE, `start`=1, `len`=0: clear `acc`, go directly to HOLD. The result is 0.
- ACC, `prod_valid`=1:
  - `acc` ← `acc` + sign-extend(`prod`) to ACC_W.
  - `cnt` ← `cnt` − 1.
  - If `cnt` was 1, go to HOLD.
- ACC, `prod_valid`=0: hold all state.
- HOLD: `out_valid`=1, and `acc`, `acc_out` and `ovf` are frozen. On `out_valid`&&`out_ready`, go to IDLE.
- Ignored inputs:
  - `start` in ACC or HOLD.
  - `prod_valid` in IDLE or HOLD; those products are discarded and `acc` is unchanged.
- Saturation:
  - If `acc_full` > 2^(PROD_W−1) − 1: `acc_out` = 0x7FFF_FFFF_FFFF_FFFF, `ovf`=1.
  - If `acc_full` < −2^(PROD_W−1): `acc_out` = 0x8000_0000_0000_0000, `ovf`=1.
  - Otherwise `acc_out` = `acc_full`[PROD_W−1:0], `ovf`=0.
- The 72-bit accumulator cannot wrap for any legal `len`, because 255·2^63 < 2^71.

## Timing
- `start` sampled at edge N moves the FSM out of IDLE by edge N; `busy`=1 after edge N.
- The last product accepted at edge M gives `out_valid`=1 after edge M, with `acc_full` already updated.
- `len`=0: `out_valid`=1 one cycle after `start`.
- Handshake completes at the edge where `out_valid`&&`out_ready` are both high; `out_valid` and `busy` are 0 after that edge.
- Back-to-back bursts: a new `start` can be accepted on the cycle after the handshake. No bubble beyond the IDLE cycle.
- `out_ready` held low keeps HOLD indefinitely with stable outputs.
- Asserting `reset` at any time, including mid-burst, returns the block to reset values immediately. In-flight products are lost.
- Throughput: one product per cycle while `prod_valid` stays high.

## Test plan
- `len`=2; products 464960160 then −143362716 with `prod_valid` on consecutive cycles.
  - Required: `out_valid` the cycle after the second product, `acc_out`=321597444, `ovf`=0.
- `len`=3; products 5, 7, −2 with one-cycle gaps of `prod_valid`=0 between them; `out_ready` held 0 for 5 cycles after `out_valid`.
  - Required: `acc_out`=10, stable through backpressure; `out_valid` drops after the cycle where `out_ready` is 1.
- `len`=2; 0x7FFF_FFFF_FFFF_FFFF twice.
  - Required: `acc_full`=0x00_FFFF_FFFF_FFFF_FFFE, `acc_out`=0x7FFF_FFFF_FFFF_FFFF, `ovf`=1.
- `len`=2; 0x8000_0000_0000_0000 twice.
  - Required: `acc_full`=0xFF_0000_0000_0000_0000, `acc_out`=0x8000_0000_0000_0000, `ovf`=1.
- Edge cases:
  - `len`=0 gives `out_valid` the next cycle with `acc_out`=0.
  - `prod_valid` pulses in IDLE are ignored; the following `len`=1 burst of 42 gives 42.
  - `start` pulsed during ACC is ignored.
- Reset mid-burst:
  - Stimulus: `len`=4, `reset` asserted asynchronously after 2 products.
  - Required: `busy`=0, `acc_full`=0 immediately; a subsequent `len`=1 burst of −259 gives `acc_out`=−259.
